msrv32_ahb_arbiter: RTL

Shares a single AHB-Lite master port between the core's instruction-fetch requester and its load/store requester, so that a unified-memory system can be built around the two-stage msrv32 core. The arbiter grants one requester at a time and drives a registered address phase. It then tracks the data phase, including wait states and two-cycle ERROR responses. It returns read data and a one-cycle ready pulse to the granted requester. Data accesses have priority, and a starvation limit guarantees forward progress for instruction fetch.

---
 rtl/msrv32_bus_pkg.sv | 25 ++
 rtl/msrv32_arb_priority.sv | 54 +++++
 rtl/msrv32_ahb_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/msrv32_bus_pkg.sv
// msrv32_bus_pkg
//   Shared types and AHB-Lite constants for the msrv32 unified-memory bus
//   arbiter: FSM state encoding, bus-owner encoding, HTRANS and HSIZE codes.
package msrv32_bus_pkg;

    // Arbiter FSM: address phase, data phase, and the second cycle of an
    // AHB ERROR response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Which requester owns the current transfer.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/msrv32_arb_priority.sv
// msrv32_arb_priority
//   Combinational grant decision between fetch (I) and load/store (D), with a
//   registered starvation counter that forces a fetch grant after
//   STARVE_LIMIT consecutive data grants made while a fetch was pending.
// Ports
//   clk_in, rst_in       clock, synchronous active-high reset
//   eval_in              a grant may be made this cycle
//   i_req_in, d_req_in   raw request levels
//   i_mask_in, d_mask_in suppress a stale request (transfer completing now)
//   grant_out            a grant is made this cycle
//   grant_owner_out      winner, valid with grant_out
import msrv32_bus_pkg::*;

module msrv32_arb_priority #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   eval_in,
    input  logic   i_req_in,
    input  logic   d_req_in,
    input  logic   i_mask_in,
    input  logic   d_mask_in,
    output logic   grant_out,
    output owner_e grant_owner_out
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q;
    logic          i_eff, d_eff, starve_hit;

    // A masked request belongs to the transfer completing this cycle, so it
    // is not a pending request: it neither competes nor counts as starving.
    assign i_eff      = i_req_in & ~i_mask_in;
    assign d_eff      = d_req_in & ~d_mask_in;
    assign starve_hit = (starve_q >= LIMIT) & i_eff;

    assign grant_out       = eval_in & (i_eff | d_eff);
    assign grant_owner_out = (d_eff && !starve_hit) ? OWNER_D : OWNER_I;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            starve_q <= '0;
        end else if (grant_out) begin
            if (grant_owner_out == OWNER_I)
                starve_q <= '0;
            else if (i_eff && starve_q < LIMIT)
                starve_q <= starve_q + 1'b1;
        end
    end

endmodule

// File: rtl/msrv32_ahb_arbiter.sv
// msrv32_ahb_arbiter
//   Shares one AHB-Lite master port between the msrv32 fetch (I) and
//   load/store (D) requesters. Registered NONSEQ address phase, data phase
//   with wait states and two-cycle ERROR handling, one-cycle ready pulse back
//   to the owner. D has priority; a starvation limit guarantees fetch progress.
// Ports
//   clk_in, rst_in                 clock, synchronous active-high reset
//   i_req/addr_in                  fetch request; i_ready/rdata/resp_out reply
//   d_req/wr/addr/wdata/wmask_in   data request; d_ready/rdata/resp_out reply
//   haddr/htrans/hwrite/hsize/hwstrb/hwdata_out, hready/hresp/hrdata_in  AHB
import msrv32_bus_pkg::*;

module msrv32_ahb_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_ready_out,
    output logic [31:0] i_rdata_out,
    output logic        i_resp_out,
    input  logic        d_req_in,
    input  logic        d_wr_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [3:0]  d_wmask_in,
    output logic        d_ready_out,
    output logic [31:0] d_rdata_out,
    output logic        d_resp_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [3:0]  hwstrb_out,
    output logic [31:0] hwdata_out,
    input  logic        hready_in,
    input  logic        hresp_in,
    input  logic [31:0] hrdata_in
);

    state_e      state_q, state_d;
    owner_e      owner_q, grant_owner;
    logic        grant, eval, i_mask, d_mask;
    logic        done, done_err;
    logic [31:0] haddr_q, wdata_q;
    logic        hwrite_q;
    logic [3:0]  wmask_q;
    logic        data_phase;

    msrv32_arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .eval_in         (eval),
        .i_req_in        (i_req_in),
        .d_req_in        (d_req_in),
        .i_mask_in       (i_mask),
        .d_mask_in       (d_mask),
        .grant_out       (grant),
        .grant_owner_out (grant_owner)
    );

    always_comb begin
        state_d  = state_q;
        eval     = 1'b0;
        i_mask   = 1'b0;
        d_mask   = 1'b0;
        done     = 1'b0;
        done_err = 1'b0;
        case (state_q)
            IDLE: begin
                eval = 1'b1;
                if (grant) state_d = ADDR;
            end
            ADDR: begin
                if (hready_in) state_d = DATA;
            end
            DATA: begin
                if (hresp_in) begin
                    // First ERROR cycle; any hready here is a slave protocol
                    // violation and is treated as the start of the error.
                    state_d = ERR;
                end else if (hready_in) begin
                    done    = 1'b1;
                    eval    = 1'b1;
                    // The completing requester still shows its old request.
                    i_mask  = (owner_q == OWNER_I);
                    d_mask  = (owner_q == OWNER_D);
                    state_d = grant ? ADDR : IDLE;
                end
            end
            ERR: begin
                // No re-grant here: the bus returns to IDLE for one cycle.
                if (hready_in) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            owner_q  <= OWNER_I;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= grant_owner;
                if (grant_owner == OWNER_D) begin
                    haddr_q  <= d_addr_in;
                    hwrite_q <= d_wr_in;
                    wdata_q  <= d_wdata_in;
                    wmask_q  <= d_wr_in ? d_wmask_in : 4'b0000;
                end else begin
                    haddr_q  <= i_addr_in;
                    hwrite_q <= 1'b0;
                    wdata_q  <= '0;
                    wmask_q  <= '0;
                end
            end
        end
    end

    assign data_phase = (state_q == DATA) || (state_q == ERR);

    assign htrans_out = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_out  = haddr_q;
    assign hwrite_out = hwrite_q;
    assign hsize_out  = HSIZE_WORD;
    assign hwdata_out = data_phase ? wdata_q : 32'h0;
    assign hwstrb_out = data_phase ? wmask_q : 4'b0000;

    // A reset landing on the completing cycle abandons the transfer, so the
    // combinational pulse is suppressed as well.
    always_comb begin
        i_ready_out = 1'b0;
        i_rdata_out = '0;
        i_resp_out  = 1'b0;
        d_ready_out = 1'b0;
        d_rdata_out = '0;
        d_resp_out  = 1'b0;
        if (done && !rst_in) begin
            if (owner_q == OWNER_D) begin
                d_ready_out = 1'b1;
                d_rdata_out = done_err ? 32'h0 : hrdata_in;
                d_resp_out  = done_err;
            end else begin
                i_ready_out = 1'b1;
                i_rdata_out = done_err ? 32'h0 : hrdata_in;
                i_resp_out  = done_err;
            end
        end
    end

endmodule
